// File: rtl/btn_debounce_pkg.sv
// btn_debounce shared types and helpers.
// State encoding and counter sizing for all channels.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } btn_state_e;

  // Width that holds every terminal count (largest value - 1).
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, qualification FSM, strobes.
// Auto-repeat while held when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_PER   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CW =
    cnt_width(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic       s1_q, s1_d;
  logic       s_q, s_d;
  btn_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       rel_q, rel_d;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          rep_q, rep_d;
  logic [CW-1:0] rlast;

  assign rlast = rep_q ? PER_LAST : DLY_LAST;
`endif

  // Next state, qualification counter and strobes.
  always_comb begin
    s1_d    = btn_raw;
    s_d     = s1_q;
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    rcnt_d  = rcnt_q;
    rep_d   = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (s_q) state_d = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!s_q) begin
          state_d = IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          rcnt_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s_q) state_d = RELEASE_CHK;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        if (rcnt_q == rlast) begin
          press_d = 1'b1;
          rcnt_d  = '0;
          rep_d   = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
`endif
      end
      RELEASE_CHK: begin
        if (s_q) begin
          state_d = HELD;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          rel_d   = 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
          rcnt_d  = '0;
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s_q     <= s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  // Repeat counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with press/release strobes.
// Optional auto-repeat: define BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int N_BTN        = 3,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int REPEAT_DLY   = 50000000,
  parameter int REPEAT_PER   = 10000000
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER)
    ) u_ch (
      .clk        (clk_100MHz),
      .rst_n      (reset_n),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (DEBOUNCE_CYC=8).
// Edge e = e-th rising clock edge after reset release.
module tb_btn_debounce;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw   = '0;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] rls;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  btn_debounce #(
    .N_BTN       (3),
    .DEBOUNCE_CYC(8),
    .REPEAT_DLY  (20),
    .REPEAT_PER  (5)
  ) dut (
    .clk_100MHz (clk),
    .reset_n    (rst_n),
    .btn_raw    (raw),
    .btn_level  (level),
    .btn_press  (press),
    .btn_release(rls)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  // Raw pin value sampled at edge e.
  function automatic logic [2:0] raw_at(input int e);
    logic [2:0] r;
    r[0] = (e >= 10 && e < 50) || (e >= 90);
    r[1] = (e >= 23 && e <= 27) || (e >= 30 && e < 70);
    r[2] = (e >= 62 && e <= 68);
    return r;
  endfunction

  function automatic logic [2:0] exp_press(input int e);
    logic [2:0] r;
    r = '0;
    r[0] = (e == 20) || (e == 100) || (e == 119);
    r[1] = (e == 40);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    r[0] = r[0] || (e == 40) || (e == 45) || (e == 50);
    r[1] = r[1] || (e == 60) || (e == 65) || (e == 70);
`endif
    return r;
  endfunction

  function automatic logic [2:0] exp_rls(input int e);
    logic [2:0] r;
    r = '0;
    r[0] = (e == 60);
    r[1] = (e == 80);
    return r;
  endfunction

  function automatic logic [2:0] exp_level(input int e);
    logic [2:0] r;
    r = '0;
    r[0] = (e >= 20 && e < 60) || (e >= 100 && e <= 105)
        || (e >= 119);
    r[1] = (e >= 40 && e < 80);
    return r;
  endfunction

  initial begin
    #12;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_press", 32'(press), 32'd0);
    chk("rst_rls", 32'(rls), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 130; e++) begin
      raw = raw_at(e);
      @(posedge clk);
      #1;
      cyc = e;
      chk("level", 32'(level), 32'(exp_level(e)));
      chk("press", 32'(press), 32'(exp_press(e)));
      chk("release", 32'(rls), 32'(exp_rls(e)));
      if (e == 105) begin
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_press", 32'(press), 32'd0);
        chk("midrst_rls", 32'(rls), 32'd0);
      end
      if (e == 108) begin
        #1;
        rst_n = 1'b1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button conditioner that sits directly upstream of the board-level FSM. It turns raw, bouncing button inputs into clean levels plus single-cycle press and release strobes, which drive the FSM's step-clock and force inputs. Each channel synchronises its input, rejects bounces with a qualification counter, and can optionally auto-repeat while a button is held.

## Interface
- N_BTN, 3: number of independent button channels.
- DEBOUNCE_CYC, 1000000: consecutive stable cycles needed to accept a change (10 ms at 100 MHz); must be ≥ 2.
- REPEAT_DLY, 50000000: hold cycles before the first auto-repeat strobe (used only with the macro).
- REPEAT_PER, 10000000: cycles between later auto-repeat strobes (used only with the macro).
- clk_100MHz  input  1  system clock; all state is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw button pins, asynchronous, 1 = pressed.
- btn_level  output  N_BTN  debounced level per channel.
- btn_press  output  N_BTN  one-cycle strobe on each accepted press (and on each repeat).
- btn_release  output  N_BTN  one-cycle strobe on each accepted release.

## Operation
- Channels are fully independent; the description below applies per channel.
- Synchroniser: two flops, raw → s1 → s, both reset to 0.
- Qualification counter cnt: clears whenever s == btn_level. It increments while s != btn_level.
- Acceptance: on the edge where s != btn_level and cnt == DEBOUNCE_CYC-1:
  - btn_level toggles;
  - cnt clears;
  - the matching strobe is asserted for exactly that following cycle.
- Bounce: any cycle with s == btn_level before acceptance restarts qualification from 0. No strobe is produced.
- FSM states:
  - IDLE: level 0, s 0.
  - PRESS_CHK: level 0, s 1, counting.
  - HELD: level 1.
  - RELEASE_CHK: level 1, s 0, counting.
- Transitions:
  - IDLE→PRESS_CHK when s = 1.
  - PRESS_CHK→IDLE on bounce; PRESS_CHK→HELD on acceptance, with btn_press.
  - HELD→RELEASE_CHK when s = 0.
  - RELEASE_CHK→HELD on bounce; RELEASE_CHK→IDLE on acceptance, with btn_release.
- btn_press and btn_release are never high in the same cycle on the same channel.
- Counter width: $clog2 of the largest of DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER. Unsigned. Saturation is never reached because the counter clears at terminal count.

## Timing
- Reset values: btn_level = 0, btn_press = 0, btn_release = 0, all counters 0, state IDLE. Outputs are registered.
- Latency: a raw edge sampled at edge t gives a btn_level change and strobe at edge t + 2 + DEBOUNCE_CYC.
- Strobe width: exactly 1 cycle. Consecutive strobes on a channel are at least DEBOUNCE_CYC cycles apart, except repeats.
- Glitches shorter than DEBOUNCE_CYC synchronised cycles produce no output change.
- Reset asserted mid-qualification or while HELD: everything returns to reset values immediately. No release strobe is emitted.
- Button held through reset release: it is treated as a fresh press, and btn_press fires 2 + DEBOUNCE_CYC cycles after reset_n rises.
- Simultaneous events on different channels are independent. Strobes may coincide.

## Configuration
- BTN_DEBOUNCE_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter runs from the acceptance edge.
  - An extra btn_press fires REPEAT_DLY cycles after acceptance, then every REPEAT_PER cycles while still HELD.
  - Entering RELEASE_CHK pauses repeats. A bounce back to HELD resumes them without resetting the repeat counter.
  - Acceptance of the release stops repeats and clears the counter.
- Macro undefined: exactly one btn_press per accepted press. The repeat counter and its logic are absent.

## Structure
- Package btn_debounce_pkg holds:
  - the state enum (IDLE, PRESS_CHK, HELD, RELEASE_CHK);
  - the counter-width helper function.
- Sub-module btn_debounce_ch implements one channel: synchroniser, counters, FSM.
- btn_debounce generates N_BTN instances of btn_debounce_ch.

## Test plan
Bench parameters: DEBOUNCE_CYC=8, REPEAT_DLY=20, REPEAT_PER=5, N_BTN=3.
- Clean press on ch0 at edge 10 → btn_level[0] rises and btn_press[0] pulses for 1 cycle at edge 20. Nothing happens on ch1 or ch2.
- Bounce: ch1 high for 5 cycles, low for 2, then high steadily from edge 30 → exactly one btn_press[1], at edge 40.
- Release of ch0 at edge 50 → btn_release[0] at edge 60; btn_level[0] = 0.
- Glitch: ch2 high for 7 cycles → no strobes, btn_level[2] stays 0.
- reset_n pulsed low for 3 cycles while ch0 is HELD → outputs go to 0 at once with no strobe; btn_press[0] fires 10 cycles after reset_n rises.
- With the macro defined, ch0 accepted at edge 20 and held → btn_press[0] at edges 20, 40, 45, 50, …, stopping once release is accepted. Without the macro, only the pulse at edge 20 appears.
